// File: rtl/mem_stage_pkg.sv
// Shared pipeline structs, access-size and FSM-state enums for the memory stage.
package mem_stage_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rf_we;
  } DEEX_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_res;
    logic [31:0] rs2_data;
    logic        mem_we;
    logic        mem_rden;
    mem_size_t   mem_size;
    logic        mem_unsigned;
    logic [1:0]  rf_wr_sel;
    DEEX_t       DEEX_prev;
  } EXMEM_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_res;
    logic [31:0] rs2_data;
    logic        mem_we;
    logic        mem_rden;
    mem_size_t   mem_size;
    logic        mem_unsigned;
    logic [1:0]  rf_wr_sel;
    DEEX_t       DEEX_prev;
  } MEMWB_t;

  function automatic MEMWB_t to_memwb(EXMEM_t e, logic v);
    MEMWB_t m;
    m.valid        = v;
    m.alu_res      = e.alu_res;
    m.rs2_data     = e.rs2_data;
    m.mem_we       = e.mem_we;
    m.mem_rden     = e.mem_rden;
    m.mem_size     = e.mem_size;
    m.mem_unsigned = e.mem_unsigned;
    m.rf_wr_sel    = e.rf_wr_sel;
    m.DEEX_prev    = e.DEEX_prev;
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane steering for stores (enables + replicated data) and
// lane select plus sign/zero extension for loads. Purely combinational.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [LANES-1:0][7:0] lane_w;
  logic [1:0]            ofs;
  logic [31:0]           sh;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_w[l] = (size == BYTE) ? st_data[7:0] :
                       (size == HALF) ? st_data[8*(l%2) +: 8] :
                                        st_data[8*l +: 8];
  end
  assign wdata = lane_w;

  always_comb begin
    be    = 4'b1111;
    ofs   = 2'd0;
    case (size)
      BYTE: begin
        be  = 4'b0001 << addr_lo;
        ofs = addr_lo;
      end
      HALF: begin
        be  = addr_lo[1] ? 4'b1100 : 4'b0011;
        ofs = {addr_lo[1], 1'b0};
      end
      default: begin
        be  = 4'b1111;
        ofs = 2'd0;
      end
    endcase
    sh = rdata >> {ofs, 3'b000};
    case (size)
      BYTE:    ldata = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      HALF:    ldata = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      default: ldata = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: stalls the pipe while one data-memory access is outstanding.
// Optional MEM_MISALIGN_CHECK_EN retires misaligned half/word accesses without a request.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  EXMEM_t      EXMEM_prev,
  output logic        stall,
  output MEMWB_t      MEMWB_out,
  output logic [31:0] D2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        bus_err
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  mem_state_t  state, state_nx;
  logic [7:0]  cnt;
  logic        memop, misal, timeout, done;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ldata_c;

  assign memop = EXMEM_prev.valid & (EXMEM_prev.mem_we | EXMEM_prev.mem_rden);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misal = ((EXMEM_prev.mem_size == HALF) & EXMEM_prev.alu_res[0]) |
                 ((EXMEM_prev.mem_size == WORD) & (|EXMEM_prev.alu_res[1:0]));
`else
  assign misal = 1'b0;
`endif

  // cnt holds the number of BUSY cycles already elapsed, so this fires on the
  // TIMEOUT_CYCLES-th BUSY cycle without an ack.
  assign timeout = (state == BUSY) & ~dmem_ack & (cnt == 8'(TIMEOUT_CYCLES - 1));

  mem_align u_align (
    .addr_lo     (EXMEM_prev.alu_res[1:0]),
    .size        (EXMEM_prev.mem_size),
    .is_unsigned (EXMEM_prev.mem_unsigned),
    .st_data     (EXMEM_prev.rs2_data),
    .rdata       (dmem_rdata),
    .be          (be_c),
    .wdata       (wdata_c),
    .ldata       (ldata_c)
  );

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (memop & ~misal) begin
          stall    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // Timeout also releases the stall so the abandoned op retires exactly once.
        done  = dmem_ack | timeout;
        stall = ~done;
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      MEMWB_out  <= '0;
      D2         <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      bus_err <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          D2  <= '0;
          if (memop & ~misal) begin
            MEMWB_out  <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= EXMEM_prev.mem_we;
            dmem_addr  <= {EXMEM_prev.alu_res[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
          end else begin
            MEMWB_out <= to_memwb(EXMEM_prev, EXMEM_prev.valid);
`ifdef MEM_MISALIGN_CHECK_EN
            misalign  <= memop & misal;
`endif
          end
        end
        BUSY: begin
          if (done) begin
            MEMWB_out <= to_memwb(EXMEM_prev, 1'b1);
            D2        <= (dmem_ack & ~EXMEM_prev.mem_we) ? ldata_c : 32'd0;
            bus_err   <= ~dmem_ack;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level model builds per-cycle expectations,
// one negedge process compares them; a few literal checks pin the model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  EXMEM_t      ex;
  MEMWB_t      mw;
  logic        stall;
  logic [31:0] D2;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        bus_err;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 CLK = ~CLK;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EXMEM_prev (ex),
    .stall      (stall),
    .MEMWB_out  (mw),
    .D2         (D2),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .bus_err    (bus_err)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign   (misalign)
`endif
  );

  typedef struct {
    logic        stall, req, we, mwv, berr, mis;
    logic [31:0] addr, wdata, mwa, d2;
    logic [3:0]  be;
  } exp_t;

  exp_t e;
  logic e_on = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // registered outputs as the model believes them to be right now
  logic        r_req, r_we, r_mwv, r_berr, r_mis;
  logic [31:0] r_addr, r_wdata, r_mwa, r_d2;
  logic [3:0]  r_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (e_on) begin
      chk("stall", 32'(stall), 32'(e.stall));
      chk("dmem_req", 32'(dmem_req), 32'(e.req));
      if (e.req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e.we));
        chk("dmem_addr", dmem_addr, e.addr);
        chk("dmem_be", 32'(dmem_be), 32'(e.be));
        chk("dmem_wdata", dmem_wdata, e.wdata);
      end
      chk("memwb_valid", 32'(mw.valid), 32'(e.mwv));
      chk("memwb_alu", mw.alu_res, e.mwa);
      chk("D2", D2, e.d2);
      chk("bus_err", 32'(bus_err), 32'(e.berr));
`ifdef MEM_MISALIGN_CHECK_EN
      chk("misalign", 32'(misalign), 32'(e.mis));
`endif
    end
  end

  function automatic logic [3:0] m_be(logic [31:0] a, mem_size_t s);
    if (s == BYTE) return 4'(1 << a[1:0]);
    if (s == HALF) return 4'(3 << (a & 32'd2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d, mem_size_t s);
    if (s == BYTE) return (d & 32'hFF) * 32'h0101_0101;
    if (s == HALF) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, mem_size_t s, logic uns);
    logic [31:0] v;
    int          bits;
    if (s == BYTE) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      bits = 8;
    end else if (s == HALF) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      bits = 16;
    end else begin
      return w;
    end
    if (!uns && v >= 32'(1 << (bits - 1))) v = v - 32'(1 << bits);
    return v;
  endfunction

  task automatic step(input logic ack, input logic [31:0] rdata, input logic exp_stall);
    dmem_ack   = ack;
    dmem_rdata = rdata;
    e.stall = exp_stall; e.req = r_req; e.we = r_we; e.addr = r_addr;
    e.be = r_be; e.wdata = r_wdata; e.mwv = r_mwv; e.mwa = r_mwa;
    e.d2 = r_d2; e.berr = r_berr; e.mis = r_mis;
    e_on = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    r_req = 0; r_we = 0; r_addr = 0; r_be = 0; r_wdata = 0;
    r_mwv = 0; r_mwa = 0; r_d2 = 0; r_berr = 0; r_mis = 0;
  endtask

  task automatic bubble();
    ex = '0;
    step(1'b0, 32'd0, 1'b0);
    r_mwv = 0; r_mwa = 0; r_d2 = 0; r_berr = 0; r_mis = 0;
  endtask

  // ack_at: BUSY cycle (1-based) that sees the ack, 0 = never; rst_at: BUSY cycle with RST
  task automatic txn(input logic [31:0] addr, input logic [31:0] rs2, input logic we,
                     input logic rd, input mem_size_t sz, input logic uns,
                     input int ack_at, input logic [31:0] rdata, input int rst_at);
    logic mop, mis, ack, to;
    ex = '0;
    ex.valid = 1'b1; ex.alu_res = addr; ex.rs2_data = rs2; ex.mem_we = we;
    ex.mem_rden = rd; ex.mem_size = sz; ex.mem_unsigned = uns; ex.rf_wr_sel = 2'd1;
    ex.DEEX_prev.pc = addr ^ 32'h1000; ex.DEEX_prev.rd = 5'd7;
    mop = we | rd;
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = mop && ((sz == HALF && addr[0]) || (sz == WORD && addr[1:0] != 2'd0));
`endif
    if (!mop || mis) begin
      step(ack_at != 0, rdata, 1'b0);
      r_mwv = 1; r_mwa = addr; r_d2 = 0; r_berr = 0; r_mis = mis;
      return;
    end
    step(1'b0, $urandom, 1'b1);
    r_req = 1; r_we = we; r_addr = addr & 32'hFFFF_FFFC; r_be = m_be(addr, sz);
    r_wdata = m_wdata(rs2, sz); r_mwv = 0; r_mwa = 0; r_d2 = 0; r_berr = 0; r_mis = 0;
    for (int k = 1; k <= TO; k++) begin
      if (k == rst_at) begin
        RST = 1'b1; dmem_ack = 1'b0; e_on = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        clear_model();
        return;
      end
      ack = (k == ack_at);
      to  = (k == TO);
      step(ack, ack ? rdata : $urandom, !(ack || to));
      if (ack || to) begin
        r_req = 0; r_we = 0; r_mwv = 1; r_mwa = addr;
        r_d2 = (ack && !we) ? m_load(rdata, addr, sz, uns) : 32'd0;
        r_berr = !ack;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    RST = 1'b1; ex = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    clear_model();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    bubble();                                    // reset state

    chk("pin_load_byte", m_load(32'h80AABBCC, 32'h103, BYTE, 1'b0), 32'hFFFF_FF80);
    chk("pin_be_half", 32'(m_be(32'h202, HALF)), 32'hC);
    chk("pin_wdata_half", m_wdata(32'hDEADBEEF, HALF), 32'hBEEF_BEEF);

    txn(32'h1234, 0, 0, 0, WORD, 0, 0, 0, 0);    // non-memop passthrough
    chk("lit_alu", mw.alu_res, 32'h1234);
    // byte load, ack on 4th BUSY cycle which is also the timeout cycle: ack wins
    txn(32'h103, 0, 0, 1, BYTE, 0, 4, 32'h80AABBCC, 0);
    chk("lit_d2_byte", D2, 32'hFFFF_FF80);
    chk("lit_no_berr", 32'(bus_err), 32'd0);
    txn(32'h202, 32'hDEADBEEF, 1, 0, HALF, 0, 2, 0, 0);
    txn(32'h300, 0, 0, 1, WORD, 0, 0, 32'h0, 0);   // no ack: timeout
    chk("lit_berr", 32'(bus_err), 32'd1);
    chk("lit_d2_to", D2, 32'd0);
    bubble();
    txn(32'h101, 0, 0, 1, BYTE, 1, 1, 32'h1234_5678, 0);
    txn(32'h002, 0, 0, 1, HALF, 0, 3, 32'h8001_7FFF, 0);
    txn(32'h000, 0, 0, 1, HALF, 1, 1, 32'h1234_F00D, 0);
    txn(32'h010, 0, 0, 1, WORD, 0, 2, 32'hCAFE_F00D, 0);
    txn(32'h003, 32'h0000_00AB, 1, 0, BYTE, 0, 1, 0, 0);
    txn(32'h020, 32'h1357_9BDF, 1, 0, WORD, 0, 3, 0, 0);
    txn(32'h055, 0, 0, 0, WORD, 0, 1, 32'hFFFF_FFFF, 0);  // ack in IDLE ignored
    bubble();
    txn(32'h400, 0, 0, 1, WORD, 0, 0, 0, 2);     // reset mid-BUSY
    ex = '0;
    step(1'b1, 32'h5A5A_5A5A, 1'b0);             // late ack ignored
    bubble();
    bubble();
    txn(32'h101, 0, 0, 1, WORD, 0, 1, 32'h7654_3210, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("lit_misalign", 32'(misalign), 32'd1);
    chk("lit_mis_noreq", 32'(dmem_req), 32'd0);
`endif
    txn(32'h203, 32'h0000_1122, 1, 0, HALF, 0, 1, 0, 0);
    bubble();
    bubble();
    e_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
